regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (REG_W_En/REG_W_Addr/REG_W_Data) between two requesters:
  - the in-order writeback stage (WB);
  - a long-latency unit (LL), e.g. a multi-cycle load or multiply path.
- Buffers LL results in a small FIFO and tracks LL destination registers in a pending scoreboard.
- Drives stall signals so that RAW and WAW hazards against in-flight LL results never reach the register file.
- Sits between the writeback stage and register_file; decode queries the scoreboard.

---
 rtl/regfile_write_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the in-order writeback
// stage and a FIFO-buffered long-latency unit, with a pending-destination scoreboard.
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WB_Valid,
  input  logic [4:0]               WB_Addr,
  input  logic [31:0]              WB_Data,
  output logic                     WB_Stall,
  input  logic                     LL_Valid,
  input  logic [4:0]               LL_Addr,
  input  logic [31:0]              LL_Data,
  output logic                     LL_Ready,
  input  logic                     ISS_Valid,
  input  logic [4:0]               ISS_Addr,
  output logic                     ISS_Stall,
  input  logic [4:0]               CHK_Addr1,
  input  logic [4:0]               CHK_Addr2,
  output logic                     CHK_Busy,
  output logic                     REG_W_En,
  output logic [4:0]               REG_W_Addr,
  output logic [31:0]              REG_W_Data,
  output logic [$clog2(DEPTH):0]   LL_Count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t            mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [31:0]    pending_q, pending_d;
  logic           en_q, en_d;
  logic [4:0]     addr_q, addr_d;
  logic [31:0]    data_q, data_d;

  logic  nonempty, wb_elig, grant_ll, grant_wb, push;
  wr_t   head;

  assign head      = mem_q[rptr_q];
  assign nonempty  = (cnt_q != '0);
  // Held low through reset so the LL unit never hands over a result that would be dropped.
  assign LL_Ready  = !RST && (cnt_q != CW'(DEPTH));
  assign push      = LL_Valid && LL_Ready;
  assign wb_elig   = WB_Valid && !pending_q[WB_Addr];
  assign grant_ll  = nonempty && (!wb_elig || (starve_q == SW'(STARVE_LIMIT)));
  assign grant_wb  = !grant_ll && wb_elig;
  assign WB_Stall  = WB_Valid && !grant_wb;
  assign ISS_Stall = ISS_Valid && pending_q[ISS_Addr];
  assign CHK_Busy  = pending_q[CHK_Addr1] | pending_q[CHK_Addr2];

  assign REG_W_En   = en_q;
  assign REG_W_Addr = addr_q;
  assign REG_W_Data = data_q;
  assign LL_Count   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, grant_ll})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    starve_d = starve_q;
    if (grant_ll || !nonempty)
      starve_d = '0;
    else if (grant_wb && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);

    en_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (grant_ll) begin
      en_d   = (head.addr != 5'd0);
      addr_d = head.addr;
      data_d = head.data;
    end else if (grant_wb) begin
      en_d   = (WB_Addr != 5'd0);
      addr_d = WB_Addr;
      data_d = WB_Data;
    end

    // Clear before set so a same-edge reissue of the popped register stays pending.
    pending_d = pending_q;
    if (grant_ll)
      pending_d[head.addr] = 1'b0;
    if (ISS_Valid && !ISS_Stall && (ISS_Addr != 5'd0))
      pending_d[ISS_Addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      if (push)     wptr_q <= wptr_q + AW'(1);
      if (grant_ll) rptr_q <= rptr_q + AW'(1);
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= '{addr: LL_Addr, data: LL_Data};
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenario tests for regfile_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_regfile_write_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic        WB_Valid, LL_Valid, ISS_Valid;
  logic [4:0]  WB_Addr, LL_Addr, ISS_Addr, CHK_Addr1, CHK_Addr2;
  logic [31:0] WB_Data, LL_Data;
  logic        WB_Stall, LL_Ready, ISS_Stall, CHK_Busy, REG_W_En;
  logic [4:0]  REG_W_Addr;
  logic [31:0] REG_W_Data;
  logic [1:0]  LL_Count;
  int pass_cnt = 0;
  int total    = 0;

  regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .WB_Valid(WB_Valid), .WB_Addr(WB_Addr), .WB_Data(WB_Data), .WB_Stall(WB_Stall),
    .LL_Valid(LL_Valid), .LL_Addr(LL_Addr), .LL_Data(LL_Data), .LL_Ready(LL_Ready),
    .ISS_Valid(ISS_Valid), .ISS_Addr(ISS_Addr), .ISS_Stall(ISS_Stall),
    .CHK_Addr1(CHK_Addr1), .CHK_Addr2(CHK_Addr2), .CHK_Busy(CHK_Busy),
    .REG_W_En(REG_W_En), .REG_W_Addr(REG_W_Addr), .REG_W_Data(REG_W_Data),
    .LL_Count(LL_Count)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic idle_inputs();
    WB_Valid = 0; WB_Addr = 0; WB_Data = 0;
    LL_Valid = 0; LL_Addr = 0; LL_Data = 0;
    ISS_Valid = 0; ISS_Addr = 0; CHK_Addr1 = 0; CHK_Addr2 = 0;
  endtask

  task automatic test_reset();
    int busy_seen;
    RST = 1; idle_inputs();
    tick();
    chk("rst_ready_low", 32'(LL_Ready), 32'd0);
    chk("rst_wen", 32'(REG_W_En), 32'd0);
    chk("rst_waddr", 32'(REG_W_Addr), 32'd0);
    chk("rst_wdata", REG_W_Data, 32'd0);
    RST = 0;
    repeat (3) tick();
    chk("idle_wen", 32'(REG_W_En), 32'd0);
    chk("idle_count", 32'(LL_Count), 32'd0);
    chk("idle_ready", 32'(LL_Ready), 32'd1);
    busy_seen = 0;
    for (int a = 0; a < 32; a++) begin
      CHK_Addr1 = 5'(a); CHK_Addr2 = 5'(31 - a); #1;
      if (CHK_Busy !== 1'b0) busy_seen++;
    end
    chk("idle_busy_any", 32'(busy_seen), 32'd0);
    CHK_Addr1 = 0; CHK_Addr2 = 0;
  endtask

  task automatic test_wb_write();
    WB_Valid = 1; WB_Addr = 5; WB_Data = 32'h1234_5678; #1;
    chk("wb_stall", 32'(WB_Stall), 32'd0);
    tick();
    WB_Valid = 0;
    chk("wb_wen", 32'(REG_W_En), 32'd1);
    chk("wb_waddr", 32'(REG_W_Addr), 32'd5);
    chk("wb_wdata", REG_W_Data, 32'h1234_5678);
    tick();
    chk("wb_idle_wen", 32'(REG_W_En), 32'd0);
    chk("wb_hold_addr", 32'(REG_W_Addr), 32'd5);
    chk("wb_hold_data", REG_W_Data, 32'h1234_5678);
  endtask

  task automatic test_ll_basic();
    ISS_Valid = 1; ISS_Addr = 7; #1;
    chk("iss7_stall", 32'(ISS_Stall), 32'd0);
    tick();
    ISS_Valid = 0; CHK_Addr1 = 7; #1;
    chk("busy7_a1", 32'(CHK_Busy), 32'd1);
    CHK_Addr1 = 0; CHK_Addr2 = 7; #1;
    chk("busy7_a2", 32'(CHK_Busy), 32'd1);
    LL_Valid = 1; LL_Addr = 7; LL_Data = 32'hDEAD_BEEF;
    tick();
    LL_Valid = 0;
    chk("ll7_count", 32'(LL_Count), 32'd1);
    chk("ll7_busy_pre", 32'(CHK_Busy), 32'd1);
    chk("ll7_nowrite_yet", 32'(REG_W_En), 32'd0);
    tick();
    chk("ll7_wen", 32'(REG_W_En), 32'd1);
    chk("ll7_waddr", 32'(REG_W_Addr), 32'd7);
    chk("ll7_wdata", REG_W_Data, 32'hDEAD_BEEF);
    chk("ll7_busy_clr", 32'(CHK_Busy), 32'd0);
    chk("ll7_count0", 32'(LL_Count), 32'd0);
    CHK_Addr2 = 0;
  endtask

  task automatic test_starve();
    WB_Valid = 1; WB_Addr = 10; WB_Data = 32'hA0;
    LL_Valid = 1; LL_Addr = 9; LL_Data = 32'h99;
    tick();
    LL_Valid = 0;
    chk("st_first_wb", 32'(REG_W_Addr), 32'd10);
    for (int k = 1; k <= 4; k++) begin
      WB_Addr = 5'(10 + k); WB_Data = 32'(k); #1;
      chk($sformatf("st_wb%0d_stall", k), 32'(WB_Stall), 32'd0);
      tick();
      chk($sformatf("st_wb%0d_addr", k), 32'(REG_W_Addr), 32'(10 + k));
    end
    WB_Addr = 15; WB_Data = 32'h15; #1;
    chk("st_forced_stall", 32'(WB_Stall), 32'd1);
    tick();
    chk("st_ll_addr", 32'(REG_W_Addr), 32'd9);
    chk("st_ll_data", REG_W_Data, 32'h99);
    chk("st_count0", 32'(LL_Count), 32'd0);
    #1;
    chk("st_wb_resume", 32'(WB_Stall), 32'd0);
    tick();
    WB_Valid = 0;
    chk("st_wb15_addr", 32'(REG_W_Addr), 32'd15);
  endtask

  task automatic test_full();
    WB_Valid = 1; WB_Addr = 20; WB_Data = 32'h20;
    LL_Valid = 1; LL_Addr = 17; LL_Data = 32'h11;
    tick();
    WB_Addr = 21; WB_Data = 32'h21; LL_Addr = 18; LL_Data = 32'h12; #1;
    chk("full_ready_b", 32'(LL_Ready), 32'd1);
    chk("full_wb_b", 32'(WB_Stall), 32'd0);
    tick();
    WB_Valid = 0; LL_Addr = 19; LL_Data = 32'h13; #1;
    chk("full_ready0", 32'(LL_Ready), 32'd0);
    chk("full_count2", 32'(LL_Count), 32'd2);
    tick();
    chk("full_e1_addr", 32'(REG_W_Addr), 32'd17);
    chk("full_e1_data", REG_W_Data, 32'h11);
    chk("full_not_accepted", 32'(LL_Count), 32'd1);
    tick();
    LL_Valid = 0;
    chk("full_e2_addr", 32'(REG_W_Addr), 32'd18);
    chk("full_pushpop_cnt", 32'(LL_Count), 32'd1);
    tick();
    chk("full_e3_addr", 32'(REG_W_Addr), 32'd19);
    chk("full_e3_data", REG_W_Data, 32'h13);
    chk("full_count0", 32'(LL_Count), 32'd0);
  endtask

  task automatic test_hazard();
    ISS_Valid = 1; ISS_Addr = 3;
    tick();
    WB_Valid = 1; WB_Addr = 3; WB_Data = 32'h300;
    LL_Valid = 1; LL_Addr = 3; LL_Data = 32'h33; #1;
    chk("hz_iss_stall", 32'(ISS_Stall), 32'd1);
    chk("hz_wb_stall_p", 32'(WB_Stall), 32'd1);
    tick();
    ISS_Valid = 0; LL_Valid = 0; #1;
    chk("hz_wb_stall_q", 32'(WB_Stall), 32'd1);
    tick();
    chk("hz_ll_addr", 32'(REG_W_Addr), 32'd3);
    chk("hz_ll_data", REG_W_Data, 32'h33);
    chk("hz_wb_go", 32'(WB_Stall), 32'd0);
    tick();
    WB_Valid = 0;
    chk("hz_wb_data", REG_W_Data, 32'h300);
    chk("hz_wb_wen", 32'(REG_W_En), 32'd1);
  endtask

  task automatic test_x0();
    WB_Valid = 1; WB_Addr = 0; WB_Data = 32'hFF; #1;
    chk("x0_stall", 32'(WB_Stall), 32'd0);
    tick();
    WB_Valid = 0;
    chk("x0_wen", 32'(REG_W_En), 32'd0);
  endtask

  task automatic test_reset_mid();
    WB_Valid = 1; WB_Addr = 22; WB_Data = 32'h22;
    LL_Valid = 1; LL_Addr = 24; LL_Data = 32'h24;
    tick();
    WB_Addr = 23; LL_Addr = 25; LL_Data = 32'h25;
    tick();
    WB_Valid = 0; LL_Valid = 0;
    chk("rm_count2", 32'(LL_Count), 32'd2);
    RST = 1;
    tick();
    chk("rm_count0", 32'(LL_Count), 32'd0);
    chk("rm_wen", 32'(REG_W_En), 32'd0);
    RST = 0;
    tick();
    chk("rm_wen_after", 32'(REG_W_En), 32'd0);
    chk("rm_ready", 32'(LL_Ready), 32'd1);
    tick();
    chk("rm_wen_after2", 32'(REG_W_En), 32'd0);
  endtask

  initial begin
    test_reset();
    test_wb_write();
    test_ll_basic();
    test_starve();
    test_full();
    test_hazard();
    test_x0();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
